// File: rtl/spi_cmd_ctrl_param_pkg.sv
// Shared command codes, status bit positions and FSM encoding for the
// parametrised SPI command controller.
package spi_cmd_pkg;

  localparam logic [7:0] CMD_LOAD_A   = 8'h10;
  localparam logic [7:0] CMD_LOAD_B   = 8'h20;
  localparam logic [7:0] CMD_START    = 8'h30;
  localparam logic [7:0] CMD_READ_RES = 8'h40;
  localparam logic [7:0] CMD_STATUS   = 8'h50;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;
  localparam int STAT_IRQ  = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_A  = 3'd1,
    ST_LOAD_B  = 3'd2,
    ST_READ    = 3'd3,
    ST_STATUS  = 3'd4,
    ST_DISCARD = 3'd5
  } state_t;

  function automatic int bytes_of(input int w);
    return (w + 7) / 8;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_cmd_ctrl_param_if.sv
// Byte-level link between the SPI byte slave (master modport) and the
// command controller (slave modport).
interface spi_cmd_ctrl_param_if;
  logic       cs_n;
  logic [7:0] spi_rx_data;
  logic       spi_rx_valid;
  logic [7:0] spi_tx_data;
  logic       spi_tx_ready;
  logic       spi_tx_done;

  modport master (
    output cs_n, spi_rx_data, spi_rx_valid, spi_tx_done,
    input  spi_tx_data, spi_tx_ready
  );

  modport slave (
    input  cs_n, spi_rx_data, spi_rx_valid, spi_tx_done,
    output spi_tx_data, spi_tx_ready
  );
endinterface

// File: rtl/spi_cmd_ctrl_param_serializer.sv
// Picks byte `sub` of element `idx` from a flat little-endian bus; bytes
// beyond the element width read as zero.
module spi_byte_serializer
  import spi_cmd_pkg::*;
#(
  parameter int W     = 32,
  parameter int COUNT = 16,
  parameter int IDX_W = 7
) (
  input  logic [COUNT*W-1:0] flat,
  input  logic [IDX_W-1:0]   idx,
  input  logic [IDX_W-1:0]   sub,
  output logic [7:0]         byte_out
);
  localparam int BYTES = bytes_of(W);

  logic [BYTES*8-1:0] elem;

  always_comb begin
    elem = '0;
    for (int i = 0; i < COUNT; i++) begin
      if (idx == IDX_W'(i)) elem[W-1:0] = flat[i*W +: W];
    end
    byte_out = 8'h00;
    for (int k = 0; k < BYTES; k++) begin
      if (sub == IDX_W'(k)) byte_out = elem[k*8 +: 8];
    end
  end
endmodule

// File: rtl/spi_cmd_ctrl_param.sv
// SPI command controller for an NxN systolic array: loads A/B operands,
// starts compute, snapshots results and streams results/status over SPI.
module spi_cmd_ctrl_param
  import spi_cmd_pkg::*;
#(
  parameter int N   = 4,
  parameter int A_W = 16,
  parameter int B_W = 8,
  parameter int R_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_cmd_ctrl_param_if.slave  spi,
  output logic [N*N*A_W-1:0]   matrix_a_flat,
  output logic [N*N*B_W-1:0]   matrix_b_flat,
  input  logic [N*N*R_W-1:0]   results_flat,
  output logic                 start_compute,
  input  logic                 compute_done,
  output logic                 irq
);
  localparam int A_BYTES   = bytes_of(A_W);
  localparam int B_BYTES   = bytes_of(B_W);
  localparam int R_BYTES   = bytes_of(R_W);
  localparam int MAX_BYTES = max3(A_BYTES, B_BYTES, R_BYTES);
  localparam int CW        = $clog2(N*N*MAX_BYTES) + 1;

  localparam logic [CW-1:0] LAST_A = CW'(N*N*A_BYTES - 1);
  localparam logic [CW-1:0] LAST_B = CW'(N*N*B_BYTES - 1);
  localparam logic [CW-1:0] LAST_R = CW'(N*N*R_BYTES - 1);

  state_t               state_reg;
  logic [CW-1:0]        idx_reg, sub_reg, cnt_reg;
  logic                 busy_reg, done_reg, err_reg, irq_reg, pend_reg;
  logic                 start_reg, tx_ready_reg;
  logic [7:0]           tx_data_reg;
  logic [N*N*R_W-1:0]   snap_reg;

  logic [7:0]    status_byte, ser_byte;
  logic [CW-1:0] last_sub, last_cnt;
  logic          a_wr, b_wr, advance;

  assign spi.spi_tx_data  = tx_data_reg;
  assign spi.spi_tx_ready = tx_ready_reg;
  assign start_compute    = start_reg;
  assign irq              = irq_reg;

  always_comb begin
    status_byte            = 8'h00;
    status_byte[STAT_BUSY] = busy_reg;
    status_byte[STAT_DONE] = done_reg;
    status_byte[STAT_ERR]  = err_reg;
    status_byte[STAT_IRQ]  = irq_reg;
  end

  always_comb begin
    last_sub = CW'(R_BYTES - 1);
    last_cnt = LAST_R;
    case (state_reg)
      ST_LOAD_A: begin last_sub = CW'(A_BYTES - 1); last_cnt = LAST_A; end
      ST_LOAD_B: begin last_sub = CW'(B_BYTES - 1); last_cnt = LAST_B; end
      default:   ;
    endcase
  end

  assign a_wr    = (state_reg == ST_LOAD_A) && spi.spi_rx_valid && !spi.cs_n;
  assign b_wr    = (state_reg == ST_LOAD_B) && spi.spi_rx_valid && !spi.cs_n;
  // One byte step of the shared idx/sub/cnt walk, for loads and reads alike.
  assign advance = a_wr || b_wr ||
                   ((state_reg == ST_READ) && tx_ready_reg && spi.spi_tx_done && !spi.cs_n);

  genvar gi;
  for (gi = 0; gi < N*N; gi++) begin : g_a
    logic [A_W-1:0] elem_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        elem_reg <= '0;
      end else if (a_wr && idx_reg == CW'(gi)) begin
        for (int b = 0; b < A_W; b++) begin
          if (sub_reg == CW'(b / 8)) elem_reg[b] <= spi.spi_rx_data[b % 8];
        end
      end
    end
    assign matrix_a_flat[gi*A_W +: A_W] = elem_reg;
  end

  for (gi = 0; gi < N*N; gi++) begin : g_b
    logic [B_W-1:0] elem_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        elem_reg <= '0;
      end else if (b_wr && idx_reg == CW'(gi)) begin
        for (int b = 0; b < B_W; b++) begin
          if (sub_reg == CW'(b / 8)) elem_reg[b] <= spi.spi_rx_data[b % 8];
        end
      end
    end
    assign matrix_b_flat[gi*B_W +: B_W] = elem_reg;
  end

  spi_byte_serializer #(
    .W     (R_W),
    .COUNT (N*N),
    .IDX_W (CW)
  ) u_ser (
    .flat     (snap_reg),
    .idx      (idx_reg),
    .sub      (sub_reg),
    .byte_out (ser_byte)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      idx_reg      <= '0;
      sub_reg      <= '0;
      cnt_reg      <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      irq_reg      <= 1'b0;
      pend_reg     <= 1'b0;
      start_reg    <= 1'b0;
      tx_ready_reg <= 1'b0;
      tx_data_reg  <= 8'h00;
      snap_reg     <= '0;
    end else begin
      start_reg <= 1'b0;

      if (advance) begin
        cnt_reg <= cnt_reg + 1'b1;
        if (sub_reg == last_sub) begin
          sub_reg <= '0;
          idx_reg <= idx_reg + 1'b1;
        end else begin
          sub_reg <= sub_reg + 1'b1;
        end
      end

      if (state_reg != ST_IDLE && spi.cs_n) begin
        state_reg    <= ST_IDLE;
        tx_ready_reg <= 1'b0;
        if (state_reg inside {ST_LOAD_A, ST_LOAD_B, ST_READ}) err_reg <= 1'b1;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (spi.spi_rx_valid && !spi.cs_n) begin
              idx_reg <= '0;
              sub_reg <= '0;
              cnt_reg <= '0;
              if (busy_reg && (spi.spi_rx_data inside
                  {CMD_LOAD_A, CMD_LOAD_B, CMD_START, CMD_READ_RES})) begin
                err_reg   <= 1'b1;
                state_reg <= ST_DISCARD;
              end else begin
                case (spi.spi_rx_data)
                  CMD_LOAD_A:   state_reg <= ST_LOAD_A;
                  CMD_LOAD_B:   state_reg <= ST_LOAD_B;
                  CMD_START: begin
                    start_reg <= 1'b1;
                    busy_reg  <= 1'b1;
                  end
                  CMD_READ_RES: state_reg <= ST_READ;
                  CMD_STATUS: begin
                    tx_data_reg  <= status_byte;
                    tx_ready_reg <= 1'b1;
                    state_reg    <= ST_STATUS;
                  end
                  default: begin
                    err_reg   <= 1'b1;
                    state_reg <= ST_DISCARD;
                  end
                endcase
              end
            end
          end
          ST_LOAD_A, ST_LOAD_B: begin
            if (advance && cnt_reg == last_cnt) state_reg <= ST_IDLE;
          end
          ST_READ: begin
            if (!tx_ready_reg) begin
              tx_data_reg  <= ser_byte;
              tx_ready_reg <= 1'b1;
            end else if (spi.spi_tx_done) begin
              tx_ready_reg <= 1'b0;
              if (cnt_reg == '0) irq_reg <= 1'b0;
              if (cnt_reg == LAST_R) begin
                state_reg <= ST_IDLE;
                done_reg  <= 1'b0;
              end
            end
          end
          ST_STATUS: begin
            if (tx_ready_reg && spi.spi_tx_done) begin
              tx_ready_reg <= 1'b0;
              err_reg      <= 1'b0;
              state_reg    <= ST_IDLE;
            end
          end
          ST_DISCARD: ;
          default: state_reg <= ST_IDLE;
        endcase
      end

      // Completion overrides same-cycle flag clears; the snapshot is held
      // stable while a READ is streaming it.
      if (compute_done && busy_reg) begin
        busy_reg <= 1'b0;
        done_reg <= 1'b1;
        irq_reg  <= 1'b1;
        if (state_reg == ST_READ) pend_reg <= 1'b1;
        else                      snap_reg <= results_flat;
      end else if (pend_reg && state_reg != ST_READ) begin
        snap_reg <= results_flat;
        pend_reg <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spi_cmd_ctrl_param.sv
// Directed bench for spi_cmd_ctrl_param: operand loads, compute/readback,
// busy rejection, cs_n aborts, unknown commands and async reset.
module tb_spi_cmd_ctrl_param;
  import spi_cmd_pkg::*;

  localparam int N   = 4;
  localparam int A_W = 16;
  localparam int B_W = 8;
  localparam int R_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N*N*A_W-1:0] matrix_a_flat;
  logic [N*N*B_W-1:0] matrix_b_flat;
  logic [N*N*R_W-1:0] results_flat;
  logic start_compute, compute_done, irq;
  logic [31:0] res_init [N*N];
  logic [31:0] exp_word;
  int checks = 0;
  int failures = 0;

  spi_cmd_ctrl_param_if spi_if();

  spi_cmd_ctrl_param #(.N(N), .A_W(A_W), .B_W(B_W), .R_W(R_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .spi           (spi_if),
    .matrix_a_flat (matrix_a_flat),
    .matrix_b_flat (matrix_b_flat),
    .results_flat  (results_flat),
    .start_compute (start_compute),
    .compute_done  (compute_done),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
    $display("check %s observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  task automatic send_byte(input logic [7:0] b);
    spi_if.spi_rx_data  = b;
    spi_if.spi_rx_valid = 1'b1;
    @(negedge clk);
    spi_if.spi_rx_valid = 1'b0;
  endtask

  task automatic cs_pulse();
    spi_if.cs_n = 1'b1;
    @(negedge clk);
    spi_if.cs_n = 1'b0;
  endtask

  task automatic tx_take(input string tag, input logic [7:0] expv);
    int n = 0;
    while (spi_if.spi_tx_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rdy"}, 32'(spi_if.spi_tx_ready), 32'd1);
    check(tag, 32'(spi_if.spi_tx_data), 32'(expv));
    spi_if.spi_tx_done = 1'b1;
    @(negedge clk);
    spi_if.spi_tx_done = 1'b0;
  endtask

  task automatic status(input string tag, input logic [7:0] expv);
    send_byte(CMD_STATUS);
    tx_take(tag, expv);
  endtask

  task automatic pulse_done();
    compute_done = 1'b1;
    @(negedge clk);
    compute_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    spi_if.cs_n         = 1'b1;
    spi_if.spi_rx_data  = 8'h00;
    spi_if.spi_rx_valid = 1'b0;
    spi_if.spi_tx_done  = 1'b0;
    compute_done        = 1'b0;
    results_flat        = '0;
    repeat (2) @(negedge clk);
    check("rst_tx_ready", 32'(spi_if.spi_tx_ready), 32'd0);
    check("rst_tx_data", 32'(spi_if.spi_tx_data), 32'd0);
    check("rst_start", 32'(start_compute), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_a0", 32'(matrix_a_flat[15:0]), 32'd0);
    rst = 1'b0;
    spi_if.cs_n = 1'b0;
    @(negedge clk);

    // 1: load A with bytes 0x01..0x20
    send_byte(CMD_LOAD_A);
    for (int i = 1; i <= 32; i++) send_byte(8'(i));
    check("a_elem0", 32'(matrix_a_flat[0*16 +: 16]), 32'h0201);
    check("a_elem7", 32'(matrix_a_flat[7*16 +: 16]), 32'h100F);
    check("a_elem15", 32'(matrix_a_flat[15*16 +: 16]), 32'h201F);
    status("t1_status", 8'h00);

    // 2: start, complete, read back 64 bytes
    send_byte(CMD_START);
    check("start_pulse", 32'(start_compute), 32'd1);
    @(negedge clk);
    check("start_clear", 32'(start_compute), 32'd0);
    for (int k = 0; k < N*N; k++) begin
      res_init[k] = (k == 0) ? 32'h12345678 : (k == 1) ? 32'hAABBCCDD : {4{8'(k)}};
      results_flat[k*32 +: 32] = res_init[k];
    end
    pulse_done();
    check("t2_irq_set", 32'(irq), 32'd1);
    status("t2_status", 8'h0A);
    results_flat = '1;
    send_byte(CMD_READ_RES);
    for (int j = 0; j < 64; j++) begin
      exp_word = res_init[j / 4] >> (8 * (j % 4));
      tx_take($sformatf("rd%0d", j), exp_word[7:0]);
      if (j == 0) check("t2_irq_clear", 32'(irq), 32'd0);
    end
    repeat (2) @(negedge clk);
    check("t2_read_exit", 32'(spi_if.spi_tx_ready), 32'd0);
    status("t2_status_end", 8'h00);

    // 3: busy handling and rejection
    send_byte(CMD_START);
    status("t3_busy", 8'h01);
    send_byte(CMD_LOAD_A);
    send_byte(8'h33);
    check("t3_a_kept", 32'(matrix_a_flat[15:0]), 32'h0201);
    cs_pulse();
    status("t3_err", 8'h05);
    status("t3_err_clr", 8'h01);
    pulse_done();
    check("t3_irq", 32'(irq), 32'd1);
    status("t3_done", 8'h0A);

    // 4: cs_n abort during B load
    send_byte(CMD_LOAD_B);
    for (int i = 0; i < 5; i++) send_byte(8'hA1 + 8'(i));
    cs_pulse();
    check("b_elem0", 32'(matrix_b_flat[0*8 +: 8]), 32'hA1);
    check("b_elem4", 32'(matrix_b_flat[4*8 +: 8]), 32'hA5);
    check("b_elem5", 32'(matrix_b_flat[5*8 +: 8]), 32'h00);
    check("b_elem15", 32'(matrix_b_flat[15*8 +: 8]), 32'h00);
    status("t4_abort", 8'h0E);
    status("t4_clr", 8'h0A);

    // 5: unknown command discards until cs_n high
    send_byte(8'h77);
    send_byte(8'h10);
    send_byte(8'h01);
    send_byte(CMD_STATUS);
    @(negedge clk);
    check("t5_discard_ready", 32'(spi_if.spi_tx_ready), 32'd0);
    check("t5_a0", 32'(matrix_a_flat[0*16 +: 16]), 32'h0201);
    check("t5_a1", 32'(matrix_a_flat[1*16 +: 16]), 32'h0403);
    cs_pulse();
    status("t5_err", 8'h0E);

    // 6: async reset mid-READ
    send_byte(CMD_READ_RES);
    tx_take("t6_rd0", 8'hFF);
    check("t6_irq_clr", 32'(irq), 32'd0);
    @(negedge clk);
    check("t6_ready_mid", 32'(spi_if.spi_tx_ready), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_ready", 32'(spi_if.spi_tx_ready), 32'd0);
    check("t6_rst_data", 32'(spi_if.spi_tx_data), 32'd0);
    check("t6_rst_irq", 32'(irq), 32'd0);
    check("t6_rst_a0", 32'(matrix_a_flat[15:0]), 32'd0);
    check("t6_rst_b0", 32'(matrix_b_flat[7:0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    status("t6_status", 8'h00);
    pulse_done();
    check("t6_idle_done_ignored", 32'(irq), 32'd0);
    status("t6_status2", 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_cmd_ctrl_param.md
Name: spi_cmd_ctrl_param

Overview:
Parametrised SPI command controller between the SPI byte slave and an N×N systolic array. It decodes command bytes and streams operand matrices A and B into internal storage. It pulses start, snapshots results on completion, raises an IRQ, and streams results and status back over SPI. It is the next generation of the fixed 4×4 controller: all sizes are parametrised, completion is counted per byte, cs_n aborts are handled, commands are rejected while busy, and an error/status register is added.

Parameters:
N, 4, array dimension; matrices hold N*N elements, row-major, element 0 first
A_W, 16, matrix A element width in bits; A_BYTES = ceil(A_W/8)
B_W, 8, matrix B element width in bits; B_BYTES = ceil(B_W/8)
R_W, 32, result element width in bits; R_BYTES = ceil(R_W/8)

Ports:
clk  in  1  single clock
rst  in  1  reset, asynchronous, active-high
cs_n  in  1  SPI chip select, active-low, synchronous to clk
spi_rx_data  in  8  received byte
spi_rx_valid  in  1  one-cycle pulse; spi_rx_data valid
spi_tx_data  out  8  byte to transmit
spi_tx_ready  out  1  spi_tx_data valid; held until spi_tx_done
spi_tx_done  in  1  one-cycle pulse; current tx byte consumed
matrix_a_flat  out  N*N*A_W  A storage; element i at [i*A_W +: A_W]
matrix_b_flat  out  N*N*B_W  B storage, same packing
results_flat  in  N*N*R_W  array results, same packing
start_compute  out  1  one-cycle start pulse
compute_done  in  1  one-cycle completion pulse
irq  out  1  level interrupt: results ready

Behaviour:
- Reset (async, rst=1): all outputs 0; storage, snapshot, counters and flags 0; state IDLE.
- Byte order is little-endian: byte k of an element maps to bits [8k+7:8k]. Upper bits beyond the element width are dropped on load and zero-filled on read.
- States: IDLE, LOAD_A, LOAD_B, READ, STATUS, DISCARD.
- IDLE: spi_rx_valid & !cs_n decodes spi_rx_data in the same cycle. There is no separate decode state.
  - 0x10 -> LOAD_A.
  - 0x20 -> LOAD_B.
  - 0x30 -> start_compute=1 next cycle, busy=1, stay IDLE.
  - 0x40 -> READ.
  - 0x50 -> STATUS.
  - Any other code sets err=1 and goes to DISCARD.
- Busy rejection: if busy=1, then 0x10, 0x20, 0x30 and 0x40 set err=1 and go to DISCARD. 0x50 is always accepted.
- LOAD_A: each rx byte is written to element idx, byte sub. After A_BYTES bytes, idx increments. After N*N*A_BYTES bytes -> IDLE.
- LOAD_B: same as LOAD_A, using B_BYTES bytes per element.
- Compute done: on compute_done, results_flat is copied into the snapshot buffer; busy=0, done=1, irq=1 next cycle. compute_done while not busy is ignored.
- READ:
  - The cycle after entry: spi_tx_data = snapshot byte 0, spi_tx_ready=1.
  - On spi_tx_done: ready=0 and the byte counter increments. Next cycle, ready=1 with the next byte (one idle cycle between bytes).
  - The first spi_tx_done clears irq.
  - After the N*N*R_BYTES-th spi_tx_done -> IDLE, done=0. Exit is counted on the total byte count, never on an element-index compare.
- STATUS: spi_tx_data = {4'b0, irq, err, done, busy}, ready=1. On spi_tx_done: ready=0, err cleared -> IDLE.
- DISCARD: ignore all rx bytes until cs_n=1 -> IDLE.
- cs_n=1 in any non-IDLE state: next cycle -> IDLE, spi_tx_ready=0.
  - If it occurs mid-LOAD or mid-READ, err=1.
  - Bytes already loaded are kept.
  - A READ abort leaves done and irq unchanged.
- Simultaneous events:
  - cs_n rising with spi_rx_valid in the same cycle: cs_n wins and the byte is dropped.
  - compute_done in the same cycle as a status snapshot: status shows the pre-update value.
  - compute_done during READ: the snapshot is not overwritten while in READ. The update is deferred one cycle after READ exits. done and irq still set immediately.
- Counters are sized $clog2(N*N*max(A_BYTES,B_BYTES,R_BYTES))+1 bits. Wrap-around is never reached.

Decomposition:
- Package spi_cmd_pkg holds:
  - Command codes CMD_LOAD_A=8'h10, CMD_LOAD_B=8'h20, CMD_START=8'h30, CMD_READ_RES=8'h40, CMD_STATUS=8'h50.
  - Status bit positions STAT_BUSY=0, STAT_DONE=1, STAT_ERR=2, STAT_IRQ=3.
  - The state encoding.
- One sub-module, spi_byte_serializer, selects byte sub of element idx from a flat bus. It is parametrised by width and element count and is used in READ.

Test Plan:
1. LOAD_A with N=4: 0x10 then 32 bytes 0x01..0x20 -> matrix_a_flat element 0 = 16'h0201, element 15 = 16'h201F; FSM back in IDLE.
2. START, then compute_done with results_00=32'h12345678, results_01=32'hAABBCCDD -> irq=1. READ returns 64 bytes beginning 78 56 34 12 DD CC BB AA. irq drops after the first spi_tx_done; READ exits only after byte 64.
3. STATUS while busy: 0x30 then 0x50 -> 0x01. Then 0x10 while busy -> rejected; a following STATUS returns 0x05, the next returns 0x01.
4. cs_n abort: 0x20, 5 bytes, then cs_n=1 -> elements 0..4 written, 5..15 unchanged, err=1, state IDLE.
5. Unknown command 0x77 followed by bytes 0x10 0x01 -> no load occurs; DISCARD until cs_n high; STATUS shows err.
6. Async rst asserted mid-READ -> all outputs 0 immediately, irq=0, state IDLE; a subsequent STATUS returns 0x00.
